mem_access: RTL and testbench
=============================

# mem_access

Memory stage of the pipelined RV32I core. It consumes the EX/MEM pipeline registers and runs loads and stores on the data-memory bus using a request/grant/response handshake. It formats load data (byte-lane extraction with sign or zero extension) and store data/byte-enables. It produces the MEM/WB pipeline registers and holds a stall asserted until each access completes.

## Interface
Parameters:
- none; all widths are fixed (RV32).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `PIP_memOper_i` in 5: memory operation.
  - [4] access valid.
  - [3] 1 = store, 0 = load.
  - [2] unsigned load.
  - [1:0] size: 00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- `PIP_alu_result_i` in 32: effective address, or the ALU result for non-memory ops.
- `PIP_second_operand_i` in 32: store data (rs2 after forwarding).
- `PIP_use_mem_i`, `PIP_write_reg_i` in 1: WB controls, forwarded.
- `PIP_rd_i` in 5: destination register, forwarded.
- `PIP_TRAP_i` in 1: upstream trap, forwarded.
- `EX_MEM_operand_o` out 32: equals `PIP_alu_result_i`; forwarding source for execute.
- `dmem_req_o` out 1: bus request.
- `dmem_we_o` out 1: write enable.
- `dmem_addr_o` out 32: `{PIP_alu_result_i[31:2],2'b00}`.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out 32: lane-replicated store data.
- `dmem_gnt_i` in 1: request accepted this cycle.
- `dmem_rvalid_i` in 1: response valid; `dmem_rdata_i` carries load data.
- `dmem_rdata_i` in 32: load data.
- `stall_o` out 1: freeze IF..EX/MEM registers.
- `PIP_alu_result_o` out 32, `PIP_mem_data_o` out 32, `PIP_use_mem_o` out 1, `PIP_write_reg_o` out 1, `PIP_rd_o` out 5, `PIP_TRAP_o` out 1: MEM/WB registers.

## Operation
- Access condition: `acc = PIP_memOper_i[4] && !PIP_TRAP_i && !misaligned`.
- FSM states: IDLE, REQ (request outstanding, not yet granted), RSP (granted, awaiting rvalid).
- IDLE:
  - `dmem_req_o = acc`.
  - `gnt` → RSP; no `gnt` → REQ.
- REQ:
  - `dmem_req_o = 1`; address, be, we and wdata are held stable (upstream is frozen).
  - `gnt` → RSP.
- RSP:
  - `dmem_req_o = 0`.
  - `rvalid` → IDLE (completion).
  - Responses are accepted for stores as well; `rdata` is ignored for stores.
- `stall_o = acc && !(state==RSP && dmem_rvalid_i)`.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`.
  - half: `4'b0011 << {addr[1],1'b0}`.
  - word: `4'b1111`.
- Store data:
  - byte: `{4{rs2[7:0]}}`.
  - half: `{2{rs2[15:0]}}`.
  - word: rs2.
- Load data:
  - `rdata >> (8*addr[1:0])`, truncated to the access size.
  - Sign-extended unless [2] is set, in which case zero-extended.
- MEM/WB update on each edge:
  - When `stall_o` = 1, a bubble is inserted: `PIP_write_reg_o`=0, `PIP_use_mem_o`=0, `PIP_TRAP_o`=0; data outputs are don't-care, and are kept at 0.
  - Otherwise all inputs are forwarded and `PIP_mem_data_o` takes the formatted load data (0 for non-loads).
- A trapped instruction (`PIP_TRAP_i`=1) issues no bus access and forwards the trap with `PIP_write_reg_o`=0.

## Timing
- Reset: FSM→IDLE; all MEM/WB outputs 0.
  - `dmem_req_o`, `dmem_we_o` and `stall_o` go low the cycle reset is seen.
  - An outstanding access is abandoned; a late `rvalid` arriving in IDLE is ignored.
- Non-memory op: 1-cycle latency, no stall.
- Memory op, minimum latency 2 cycles:
  - cycle 0: `req`+`gnt` while stalled.
  - cycle 1: `rvalid`, `stall_o`=0; MEM/WB captures at the end of cycle 1.
- Each extra wait cycle for `gnt` or `rvalid` adds one stall cycle.
- `gnt` and `rvalid` in the same cycle while in IDLE: `rvalid` is ignored; a response must come at least one cycle after its grant.
- Back-to-back accesses: the next request may be issued in the cycle after completion (IDLE again).
- `dmem_req_o` depends combinationally on EX/MEM inputs and state. `stall_o` depends combinationally on `dmem_rvalid_i`. There is no combinational path from `gnt` to `req`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - No bus request is issued, there is no stall, and `PIP_TRAP_o`=1 with `PIP_write_reg_o`=0 on the next edge.
- Undefined:
  - `misaligned` is tied to 0.
  - Low address bits below the access size are forced to zero for lane selection (half uses addr[1], word uses none).
  - The access proceeds normally.

## Test plan
- ADD result 0x1234, rd=5, write_reg=1, no mem op → next cycle `PIP_alu_result_o`=0x1234, `PIP_rd_o`=5, `stall_o` never high.
- LB addr 0x1003, rdata 0x80FF_0000 with `gnt` in cycle 0 and `rvalid` in cycle 1 → be=1000; `PIP_mem_data_o`=0xFFFF_FF80; `stall_o` high for exactly 1 cycle.
- LHU addr 0x2002, rdata 0xBEEF_1234 with `gnt` delayed 2 cycles and `rvalid` 3 cycles after grant → `PIP_mem_data_o`=0x0000_BEEF; 5 stall cycles; `req`/addr stable while in REQ; a bubble on MEM/WB each stall cycle.
- SB addr 0x101, rs2 0xAABB_CCDD → `we`=1, be=0010, wdata=0xDDDD_DDDD; `PIP_write_reg_o` forwarded as 0.
- Reset asserted while in RSP, then a stray `rvalid` → outputs 0, FSM IDLE, `stall_o` 0, stray response ignored; a following LW completes normally.
- With `MEM_MISALIGN_TRAP_EN`, LW addr 0x3002 → no `dmem_req_o`, `PIP_TRAP_o`=1 next cycle; without the macro → addr 0x3000, be=1111, load completes.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory bus between the memory stage and data memory.
//   master (memory stage): drives req/we/addr/be/wdata, receives gnt/rvalid/rdata.
//   slave  (data memory) : the reverse.
// Handshake: req held until gnt; response (rvalid/rdata) arrives at least one
// cycle after its grant.
interface mem_access_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: RV32I memory stage.
// Takes EX/MEM registers, runs loads/stores over a req/gnt/rvalid bus,
// formats byte-lane load/store data and produces the MEM/WB registers.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   PIP_*_i               : EX/MEM pipeline registers
//   dmem (master modport) : data-memory bus
//   EX_MEM_operand_o      : forwarding source for execute
//   stall_o               : freeze IF..EX/MEM while an access is in flight
//   PIP_*_o               : MEM/WB pipeline registers
// Option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently aligning them.
module mem_access (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   PIP_memOper_i,
  input  logic [31:0]  PIP_alu_result_i,
  input  logic [31:0]  PIP_second_operand_i,
  input  logic         PIP_use_mem_i,
  input  logic         PIP_write_reg_i,
  input  logic [4:0]   PIP_rd_i,
  input  logic         PIP_TRAP_i,
  output logic [31:0]  EX_MEM_operand_o,
  mem_access_if.master dmem,
  output logic         stall_o,
  output logic [31:0]  PIP_alu_result_o,
  output logic [31:0]  PIP_mem_data_o,
  output logic         PIP_use_mem_o,
  output logic         PIP_write_reg_o,
  output logic [4:0]   PIP_rd_o,
  output logic         PIP_TRAP_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_e;
  state_e state_q;

  logic [1:0]  size, lane;
  logic        is_byte, is_half, misaligned, trap_all, acc, is_store;
  logic [31:0] rs2, sh, ld_data;

  assign size     = PIP_memOper_i[1:0];
  assign is_store = PIP_memOper_i[3];
  assign is_byte  = (size == 2'b00);
  assign is_half  = (size == 2'b01);
  assign rs2      = PIP_second_operand_i;

  // Lane select ignores address bits below the access size.
  assign lane = is_byte ? PIP_alu_result_i[1:0] :
                is_half ? {PIP_alu_result_i[1], 1'b0} : 2'b00;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = PIP_memOper_i[4] &&
                      ((is_half && PIP_alu_result_i[0]) ||
                       (!is_byte && !is_half && (PIP_alu_result_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign trap_all = PIP_TRAP_i | misaligned;
  assign acc      = PIP_memOper_i[4] & ~PIP_TRAP_i & ~misaligned;

  assign EX_MEM_operand_o = PIP_alu_result_i;

  // Bus outputs; gated by reset so nothing is driven in the reset cycle.
  assign dmem.dmem_req_o   = ~reset & ((state_q == S_IDLE & acc) | (state_q == S_REQ));
  assign dmem.dmem_we_o    = ~reset & acc & is_store;
  assign dmem.dmem_addr_o  = {PIP_alu_result_i[31:2], 2'b00};
  assign dmem.dmem_be_o    = is_byte ? (4'b0001 << lane) :
                             is_half ? (4'b0011 << lane) : 4'b1111;
  assign dmem.dmem_wdata_o = is_byte ? {4{rs2[7:0]}} :
                             is_half ? {2{rs2[15:0]}} : rs2;

  // Completion is the RSP cycle that sees rvalid; stall releases combinationally.
  assign stall_o = ~reset & acc & ~(state_q == S_RSP & dmem.dmem_rvalid_i);

  // Load formatting: shift selected lane down, then sign/zero extend.
  assign sh = dmem.dmem_rdata_i >> {lane, 3'b000};
  always_comb begin
    ld_data = sh;
    if (is_byte)      ld_data = {{24{~PIP_memOper_i[2] & sh[7]}},  sh[7:0]};
    else if (is_half) ld_data = {{16{~PIP_memOper_i[2] & sh[15]}}, sh[15:0]};
  end

  // FSM; an rvalid seen outside RSP (stray or same-cycle as gnt) is ignored.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (acc) state_q <= dmem.dmem_gnt_i ? S_RSP : S_REQ;
        S_REQ:   if (dmem.dmem_gnt_i) state_q <= S_RSP;
        S_RSP:   if (dmem.dmem_rvalid_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // MEM/WB next state: bubble (all zero) while stalled.
  logic [31:0] alu_d, mem_d, alu_q, mem_q;
  logic        use_d, wr_d, trap_d, use_q, wr_q, trap_q;
  logic [4:0]  rd_d, rd_q;

  always_comb begin
    alu_d  = '0;
    mem_d  = '0;
    use_d  = 1'b0;
    wr_d   = 1'b0;
    rd_d   = '0;
    trap_d = 1'b0;
    if (!stall_o) begin
      alu_d  = PIP_alu_result_i;
      use_d  = PIP_use_mem_i;
      wr_d   = PIP_write_reg_i & ~trap_all;
      rd_d   = PIP_rd_i;
      trap_d = trap_all;
      if (acc && !is_store) mem_d = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q  <= '0;
      mem_q  <= '0;
      use_q  <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= '0;
      trap_q <= 1'b0;
    end else begin
      alu_q  <= alu_d;
      mem_q  <= mem_d;
      use_q  <= use_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      trap_q <= trap_d;
    end
  end

  assign PIP_alu_result_o = alu_q;
  assign PIP_mem_data_o   = mem_q;
  assign PIP_use_mem_o    = use_q;
  assign PIP_write_reg_o  = wr_q;
  assign PIP_rd_o         = rd_q;
  assign PIP_TRAP_o       = trap_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access (directed + random accesses
// against a lane/extension reference model).
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  oper;
  logic [31:0] alu, rs2;
  logic        use_mem, wr, trap;
  logic [4:0]  rd;
  logic [31:0] ex_op, alu_o, mem_o;
  logic        stall, use_o, wr_o, trap_o;
  logic [4:0]  rd_o;
  int          n_vec = 0;
  int          n_err = 0;

  mem_access_if bus();

  mem_access dut (
    .clk(clk), .reset(reset),
    .PIP_memOper_i(oper), .PIP_alu_result_i(alu), .PIP_second_operand_i(rs2),
    .PIP_use_mem_i(use_mem), .PIP_write_reg_i(wr), .PIP_rd_i(rd), .PIP_TRAP_i(trap),
    .EX_MEM_operand_o(ex_op), .dmem(bus), .stall_o(stall),
    .PIP_alu_result_o(alu_o), .PIP_mem_data_o(mem_o), .PIP_use_mem_o(use_o),
    .PIP_write_reg_o(wr_o), .PIP_rd_o(rd_o), .PIP_TRAP_o(trap_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    oper = 5'd0; alu = 32'd0; rs2 = 32'd0; use_mem = 1'b0; wr = 1'b0; rd = 5'd0; trap = 1'b0;
    bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = 32'd0;
  endtask

  // One access: gnt g cycles after issue, rvalid r cycles after gnt.
  // stray puts an extra rvalid in cycle 0, which must be ignored.
  task automatic run_access(input logic st, input logic uns, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input int g, input int r,
                            input logic [4:0] rdn, input logic stray, input string tag);
    int eff, off;
    logic [31:0] ebe, ewd, v, emd;
    eff = (sz == 2'd3) ? 2 : int'(sz);
    off = (eff == 0) ? int'(addr % 4) : (eff == 1) ? int'(addr & 2) : 0;
    ebe = (eff == 0) ? (32'd1 << off) : (eff == 1) ? (32'd3 << off) : 32'd15;
    ewd = (eff == 0) ? data[7:0] * 32'h0101_0101 :
          (eff == 1) ? data[15:0] * 32'h0001_0001 : data;
    v = rdata >> (8 * off);
    if (eff == 0) begin
      v = v & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (eff == 1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end
    emd = st ? 32'd0 : v;
    oper = {1'b1, st, uns, sz}; alu = addr; rs2 = data;
    use_mem = !st; wr = !st; rd = rdn; trap = 1'b0;
    for (int c = 0; c <= g + r; c++) begin
      bus.dmem_gnt_i    = (c == g);
      bus.dmem_rvalid_i = (c == g + r) || (stray && c == 0);
      bus.dmem_rdata_i  = (c == g + r) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      n_vec++;
      if (bus.dmem_req_o !== (c <= g)) begin
        n_err++; $display("FAIL %s req c=%0d got %b exp %b", tag, c, bus.dmem_req_o, (c <= g));
      end
      n_vec++;
      if (stall !== (c < g + r)) begin
        n_err++; $display("FAIL %s stall c=%0d got %b exp %b", tag, c, stall, (c < g + r));
      end
      if (c <= g) begin
        n_vec++;
        if (bus.dmem_addr_o !== (addr & ~32'd3) || bus.dmem_be_o !== ebe[3:0] ||
            bus.dmem_we_o !== st || (st && bus.dmem_wdata_o !== ewd)) begin
          n_err++;
          $display("FAIL %s bus c=%0d got a=%h be=%b we=%b wd=%h exp a=%h be=%b we=%b wd=%h",
                   tag, c, bus.dmem_addr_o, bus.dmem_be_o, bus.dmem_we_o, bus.dmem_wdata_o,
                   addr & ~32'd3, ebe[3:0], st, ewd);
        end
      end
      @(posedge clk); #1;
      n_vec++;
      if (c < g + r) begin
        if (wr_o !== 1'b0 || use_o !== 1'b0 || trap_o !== 1'b0) begin
          n_err++; $display("FAIL %s bubble c=%0d got wr=%b use=%b trap=%b exp 0", tag, c, wr_o, use_o, trap_o);
        end
      end else begin
        if (alu_o !== addr || mem_o !== emd || wr_o !== !st || rd_o !== rdn ||
            use_o !== !st || trap_o !== 1'b0) begin
          n_err++;
          $display("FAIL %s memwb got alu=%h md=%h wr=%b rd=%0d use=%b trap=%b exp alu=%h md=%h wr=%b rd=%0d",
                   tag, alu_o, mem_o, wr_o, rd_o, use_o, trap_o, addr, emd, !st, rdn);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    oper = 5'b10010; alu = 32'h40;   // valid LW held during reset: must not request
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.dmem_req_o !== 1'b0 || stall !== 1'b0 || bus.dmem_we_o !== 1'b0) begin
      n_err++; $display("FAIL reset_comb got req=%b stall=%b we=%b exp 0", bus.dmem_req_o, stall, bus.dmem_we_o);
    end
    n_vec++;
    if (alu_o !== 0 || mem_o !== 0 || wr_o !== 0 || use_o !== 0 || rd_o !== 0 || trap_o !== 0) begin
      n_err++; $display("FAIL reset_regs got alu=%h md=%h wr=%b exp 0", alu_o, mem_o, wr_o);
    end
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_alu_op(input logic [31:0] res, input logic [4:0] rdn, input string tag);
    oper = 5'd0; alu = res; rd = rdn; wr = 1'b1;
    @(negedge clk);
    n_vec++;
    if (stall !== 1'b0 || bus.dmem_req_o !== 1'b0 || ex_op !== res) begin
      n_err++; $display("FAIL %s comb got stall=%b req=%b ex=%h exp 0 0 %h", tag, stall, bus.dmem_req_o, ex_op, res);
    end
    @(posedge clk); #1;
    n_vec++;
    if (alu_o !== res || rd_o !== rdn || wr_o !== 1'b1 || mem_o !== 32'd0 || trap_o !== 1'b0) begin
      n_err++; $display("FAIL %s memwb got alu=%h rd=%0d wr=%b md=%h exp %h %0d 1 0", tag, alu_o, rd_o, wr_o, mem_o, res, rdn);
    end
    idle_inputs();
  endtask

  task automatic test_directed();
    test_alu_op(32'h1234, 5'd5, "add");
    run_access(1'b0, 1'b0, 2'b00, 32'h1003, 32'd0, 32'h80FF_0000, 0, 1, 5'd7, 1'b0, "lb");
    n_vec++;
    if (mem_o !== 32'hFFFF_FF80) begin
      n_err++; $display("FAIL lb_value got %h exp ffffff80", mem_o);
    end
    run_access(1'b0, 1'b1, 2'b01, 32'h2002, 32'd0, 32'hBEEF_1234, 2, 3, 5'd9, 1'b0, "lhu");
    n_vec++;
    if (mem_o !== 32'h0000_BEEF) begin
      n_err++; $display("FAIL lhu_value got %h exp 0000beef", mem_o);
    end
    run_access(1'b1, 1'b0, 2'b00, 32'h101, 32'hAABB_CCDD, 32'd0, 1, 1, 5'd3, 1'b0, "sb");
    n_vec++;
    if (wr_o !== 1'b0) begin
      n_err++; $display("FAIL sb_wr got %b exp 0", wr_o);
    end
  endtask

  task automatic test_back_to_back();
    // gnt and rvalid together in IDLE: rvalid must be ignored
    run_access(1'b0, 1'b0, 2'b10, 32'h500, 32'd0, 32'h1357_9BDF, 0, 2, 5'd1, 1'b1, "b2b_0");
    run_access(1'b0, 1'b0, 2'b01, 32'h506, 32'd0, 32'h8001_7FFF, 0, 1, 5'd2, 1'b0, "b2b_1");
    run_access(1'b1, 1'b0, 2'b01, 32'h50A, 32'h0000_CAFE, 32'd0, 1, 1, 5'd0, 1'b0, "b2b_2");
  endtask

  task automatic test_trap();
    oper = 5'b10000; alu = 32'h77; trap = 1'b1; wr = 1'b1; rd = 5'd4;
    bus.dmem_gnt_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.dmem_req_o !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL trap_comb got req=%b stall=%b exp 0 0", bus.dmem_req_o, stall);
    end
    @(posedge clk); #1;
    n_vec++;
    if (trap_o !== 1'b1 || wr_o !== 1'b0) begin
      n_err++; $display("FAIL trap_memwb got trap=%b wr=%b exp 1 0", trap_o, wr_o);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_rsp();
    oper = 5'b10010; alu = 32'h40; wr = 1'b1; use_mem = 1'b1; rd = 5'd6;
    bus.dmem_gnt_i = 1'b1;
    @(posedge clk); #1;              // now in RSP
    bus.dmem_gnt_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.dmem_req_o !== 1'b0 || stall !== 1'b0 || bus.dmem_we_o !== 1'b0) begin
      n_err++; $display("FAIL rst_rsp_comb got req=%b stall=%b we=%b exp 0", bus.dmem_req_o, stall, bus.dmem_we_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;
    if (alu_o !== 0 || mem_o !== 0 || wr_o !== 0 || use_o !== 0 || rd_o !== 0 || trap_o !== 0) begin
      n_err++; $display("FAIL rst_rsp_regs got alu=%h wr=%b use=%b exp 0", alu_o, wr_o, use_o);
    end
    idle_inputs();
    // stray rvalid arrives together with a fresh LW in IDLE
    run_access(1'b0, 1'b0, 2'b10, 32'h44, 32'd0, 32'h0BAD_F00D, 1, 1, 5'd8, 1'b1, "lw_after_rst");
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    oper = 5'b10010; alu = 32'h3002; wr = 1'b1; use_mem = 1'b1; rd = 5'd10;
    bus.dmem_gnt_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.dmem_req_o !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL misalign_comb got req=%b stall=%b exp 0 0", bus.dmem_req_o, stall);
    end
    @(posedge clk); #1;
    n_vec++;
    if (trap_o !== 1'b1 || wr_o !== 1'b0) begin
      n_err++; $display("FAIL misalign_memwb got trap=%b wr=%b exp 1 0", trap_o, wr_o);
    end
    idle_inputs();
`else
    run_access(1'b0, 1'b0, 2'b10, 32'h3002, 32'd0, 32'hCAFE_F00D, 0, 1, 5'd10, 1'b0, "lw_misalign");
    n_vec++;
    if (mem_o !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL lw_misalign_value got %h exp cafef00d", mem_o);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        test_alu_op($urandom, 5'($urandom_range(0, 31)), "rnd_alu");
      end else begin
        logic [31:0] a;
        logic [1:0]  sz;
        a  = $urandom;
        sz = 2'($urandom_range(0, 3));
`ifdef MEM_MISALIGN_TRAP_EN
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz != 2'd0) a[1:0] = 2'b00;
`endif
        run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, a, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(1, 3), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), "rnd_mem");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_trap();
    test_reset_in_rsp();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
